// File: rtl/tl_d_pkg.sv
// Shared TileLink D-channel definitions for the L2 response deserialiser.
package tl_d_pkg;

    // D-channel opcodes
    localparam logic [2:0] TL_D_ACCESSACK     = 3'd0;
    localparam logic [2:0] TL_D_ACCESSACKDATA = 3'd1;
    localparam logic [2:0] TL_D_GRANT         = 3'd4;
    localparam logic [2:0] TL_D_GRANTDATA     = 3'd5;
    localparam logic [2:0] TL_D_RELEASEACK    = 3'd6;

    // Widest low source field a buffered beat can carry (supports NoRPM up to 256).
    localparam int TL_D_SRCW = 8;

    // One beat is 16 bytes (log2 = 4); the largest legal data response is 4 KiB.
    localparam logic [7:0] TL_D_BEAT_SIZE = 8'd4;
    localparam logic [7:0] TL_D_MAX_SIZE  = 8'd12;

    typedef enum logic {
        TL_D_IDLE,
        TL_D_BURST
    } tl_d_state_e;

    typedef struct packed {
        logic [2:0]           opcode;
        logic [1:0]           param;
        logic [7:0]           size;
        logic [TL_D_SRCW-1:0] source;
        logic                 sink;
        logic                 denied;
        logic                 corrupt;
        logic [127:0]         data;
        logic                 last;
    } tl_d_beat_t;

    function automatic logic tl_d_is_data(input logic [2:0] opcode);
        return (opcode == TL_D_ACCESSACKDATA) || (opcode == TL_D_GRANTDATA);
    endfunction

    // Beats in a response; oversize data responses report 1 and are rejected by the caller.
    function automatic logic [8:0] tl_d_beats(input logic [2:0] opcode, input logic [7:0] size);
        logic [8:0] beats;
        beats = 9'd1;
        if (tl_d_is_data(opcode) && (size > TL_D_BEAT_SIZE) && (size <= TL_D_MAX_SIZE)) begin
            beats = 9'd1 << (size - TL_D_BEAT_SIZE);
        end
        return beats;
    endfunction

endpackage

// File: rtl/tile_link_deserialiser_fifo2.sv
// Two-entry FIFO of D-channel beats with an occupancy count; one per upstream port.
module tl_d_fifo2
    import tl_d_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  tl_d_beat_t push_beat_i,
    output logic       valid_o,
    output tl_d_beat_t beat_o,
    input  logic       ready_i,
    output logic [1:0] cnt_o
);

    tl_d_beat_t mem_q [2];
    tl_d_beat_t mem_d [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] cnt_q, cnt_d;
    logic       push_ok;
    logic       pop;

    // Next-state for pointers, count and storage.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        push_ok  = push_i && (cnt_q != 2'd2);
        pop      = (cnt_q != 2'd0) && ready_i;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_beat_i;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together.
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Beat storage.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the count gates validity, so stale contents are never seen.
        mem_q <= mem_d;
    end

    assign valid_o = (cnt_q != 2'd0);
    assign beat_o  = mem_q[rd_ptr_q];
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/tile_link_deserialiser.sv
// Routes the L2 D channel back to TUL+2 upstream ports by the port index in the
// source field, keeping multi-beat responses together and dropping bad routes.
module tile_link_deserialiser
    import tl_d_pkg::*;
#(
    parameter  int MADRBITS = 32,
    parameter  int NoRPM    = 2,
    parameter  int TUL      = 2,
    localparam int NP       = TUL + 2,
    localparam int PW       = $clog2(TUL + 2),
    localparam int LW       = $clog2(NoRPM),
    localparam int SW       = PW + LW
) (
    input  logic          l2_cache_clk_i,
    input  logic          l2_cache_rst_ni,
    input  logic [2:0]    l2_d_opcode_i,
    input  logic [1:0]    l2_d_param_i,
    input  logic [7:0]    l2_d_size_i,
    input  logic [SW-1:0] l2_d_source_i,
    input  logic          l2_d_sink_i,
    input  logic          l2_d_denied_i,
    input  logic          l2_d_corrupt_i,
    input  logic [127:0]  l2_d_data_i,
    input  logic          l2_d_valid_i,
    output logic          l2_d_ready_o,
    output logic [2:0]    d_opcode_o  [0:TUL+1],
    output logic [1:0]    d_param_o   [0:TUL+1],
    output logic [7:0]    d_size_o    [0:TUL+1],
    output logic [LW-1:0] d_source_o  [0:TUL+1],
    output logic          d_sink_o    [0:TUL+1],
    output logic          d_denied_o  [0:TUL+1],
    output logic          d_corrupt_o [0:TUL+1],
    output logic [127:0]  d_data_o    [0:TUL+1],
    output logic          d_last_o    [0:TUL+1],
    output logic          d_valid_o   [0:TUL+1],
    input  logic          d_ready_i   [0:TUL+1],
    output logic          route_err_o
);

    // The D channel carries no address; the width is kept only for a uniform parameter set.
    localparam int addr_w_unused = MADRBITS;

    tl_d_state_e   state_q, state_d;
    logic [PW-1:0] lock_q, lock_d;
    logic [7:0]    beat_cnt_q, beat_cnt_d;
    logic          err_q, err_d;

    logic [PW-1:0] in_port;
    logic [PW-1:0] dst;
    logic          dst_oor;
    logic          size_err;
    logic          err_beat;
    logic [8:0]    beats;
    logic          dst_full;
    logic          accept;
    logic          push;
    tl_d_beat_t    in_beat;

    logic [1:0]    fifo_cnt  [NP];
    logic          push_vec  [NP];
    tl_d_beat_t    port_beat [NP];
    logic [NP-1:0] src_hi_unused;

    assign in_port  = l2_d_source_i[SW-1 -: PW];
    assign dst      = (state_q == TL_D_BURST) ? lock_q : in_port;
    assign dst_oor  = ({1'b0, dst} >= (PW + 1)'(NP));
    assign size_err = tl_d_is_data(l2_d_opcode_i) && (l2_d_size_i > TL_D_MAX_SIZE);
    assign beats    = tl_d_beats(l2_d_opcode_i, l2_d_size_i);

    // Mid-burst beats follow the locked port and are never treated as errors.
    assign err_beat = (state_q == TL_D_IDLE) && (dst_oor || size_err);

    // Fullness of the destination buffer; unmatched (out-of-range) ports read as not full.
    always_comb begin
        dst_full = 1'b0;
        for (int i = 0; i < NP; i++) begin
            if (dst == PW'(i)) begin
                dst_full = (fifo_cnt[i] == 2'd2);
            end
        end
    end

    // Ready depends only on registered counts and the input source, never on d_ready_i.
    assign l2_d_ready_o = err_beat || !dst_full;
    assign accept       = l2_d_valid_i && l2_d_ready_o;
    assign push         = accept && !err_beat;

    assign in_beat.opcode  = l2_d_opcode_i;
    assign in_beat.param   = l2_d_param_i;
    assign in_beat.size    = l2_d_size_i;
    assign in_beat.source  = TL_D_SRCW'(l2_d_source_i[LW-1:0]);
    assign in_beat.sink    = l2_d_sink_i;
    assign in_beat.denied  = l2_d_denied_i;
    assign in_beat.corrupt = l2_d_corrupt_i;
    assign in_beat.data    = l2_d_data_i;
    assign in_beat.last    = (state_q == TL_D_BURST) ? (beat_cnt_q == 8'd1) : (beats == 9'd1);

    // Burst tracker and sticky error: lock the port on a multi-beat first beat, count down.
    always_comb begin
        state_d    = state_q;
        lock_d     = lock_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q || (accept && err_beat);
        case (state_q)
            TL_D_IDLE: begin
                if (push && (beats > 9'd1)) begin
                    state_d    = TL_D_BURST;
                    lock_d     = dst;
                    beat_cnt_d = 8'(beats - 9'd1);
                end
            end
            TL_D_BURST: begin
                if (accept) begin
                    beat_cnt_d = beat_cnt_q - 8'd1;
                    if (beat_cnt_q == 8'd1) begin
                        state_d = TL_D_IDLE;
                    end
                end
            end
        endcase
    end

    // Burst and error state registers.
    always_ff @(posedge l2_cache_clk_i or negedge l2_cache_rst_ni) begin
        if (!l2_cache_rst_ni) begin
            state_q    <= TL_D_IDLE;
            lock_q     <= '0;
            beat_cnt_q <= 8'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_q     <= lock_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
        end
    end

    assign route_err_o = err_q;

    for (genvar g = 0; g < NP; g++) begin : g_port
        assign push_vec[g] = push && (dst == PW'(g));

        tl_d_fifo2 u_fifo (
            .clk         (l2_cache_clk_i),
            .rst_n       (l2_cache_rst_ni),
            .push_i      (push_vec[g]),
            .push_beat_i (in_beat),
            .valid_o     (d_valid_o[g]),
            .beat_o      (port_beat[g]),
            .ready_i     (d_ready_i[g]),
            .cnt_o       (fifo_cnt[g])
        );

        assign d_opcode_o[g]    = port_beat[g].opcode;
        assign d_param_o[g]     = port_beat[g].param;
        assign d_size_o[g]      = port_beat[g].size;
        assign d_source_o[g]    = port_beat[g].source[LW-1:0];
        assign d_sink_o[g]      = port_beat[g].sink;
        assign d_denied_o[g]    = port_beat[g].denied;
        assign d_corrupt_o[g]   = port_beat[g].corrupt;
        assign d_data_o[g]      = port_beat[g].data;
        assign d_last_o[g]      = port_beat[g].last;
        assign src_hi_unused[g] = ^port_beat[g].source[TL_D_SRCW-1:LW];
    end

endmodule

// File: doc/tile_link_deserialiser.md
# tile_link_deserialiser

Response-side counterpart of the L2 A-channel serialiser. It takes the single TileLink D channel leaving the L2 cache and routes each beat back to the upstream port that issued the request. The routing key is the port index held in the upper bits of `l2_d_source_i`. Each port gets a 2-entry buffer, and multi-beat responses are routed as one burst with a last-beat flag. Out-of-range routing and oversize bursts are dropped and recorded in a sticky error flag.

## Interface
Parameters:
- `MADRBITS`, 32: address width; carried for package consistency, no address on D.
- `NoRPM`, 2: requestors per upstream port; the low source field is `$clog2(NoRPM)` bits.
- `TUL`, 2: the block has `TUL+2` upstream ports; `PW = $clog2(TUL+2)` bits of port index.

Ports (arrays are `[0:TUL+1]`). Clock is `l2_cache_clk_i`; reset is `l2_cache_rst_ni`, asynchronous and active-low:
- `l2_cache_clk_i` in 1: clock.
- `l2_cache_rst_ni` in 1: async active-low reset.
- `l2_d_opcode_i` in 3, `l2_d_param_i` in 2, `l2_d_size_i` in 8: D fields; size is log2 bytes.
- `l2_d_source_i` in `PW+$clog2(NoRPM)`: `{port, source}`.
- `l2_d_sink_i` in 1: sink ID.
- `l2_d_denied_i` in 1, `l2_d_corrupt_i` in 1: status bits.
- `l2_d_data_i` in 128: beat data.
- `l2_d_valid_i` in 1, `l2_d_ready_o` out 1: L2-side handshake.
- `d_opcode_o[i]` out 3, `d_param_o[i]` out 2, `d_size_o[i]` out 8, `d_source_o[i]` out `$clog2(NoRPM)`, `d_sink_o[i]` out 1, `d_denied_o[i]` out 1, `d_corrupt_o[i]` out 1, `d_data_o[i]` out 128: per-port response fields.
- `d_last_o[i]` out 1: the beat is the final beat of its response.
- `d_valid_o[i]` out 1, `d_ready_i[i]` in 1: per-port handshake.
- `route_err_o` out 1: sticky error flag.

## Operation
- A beat on the L2 side is accepted when `l2_d_valid_i & l2_d_ready_o`.
- Destination: `dst` is the locked port while a burst is in progress. Otherwise it is `l2_d_source_i[top PW bits]`.
- `l2_d_ready_o = (dst >= TUL+2) | (cnt[dst] != 2)`. It depends only on registered FIFO counts and the input source, never on `d_ready_i`.
- Beat count:
  - Data opcodes (AccessAckData=1, GrantData=5) need `beats = (size<=4) ? 1 : 1<<(size-4)`.
  - All other opcodes are 1 beat.
  - A data opcode with size > 12 is an error.
- Burst tracking:
  - State IDLE: on an accepted first beat with `beats>1`, lock `dst`, load `beat_cnt = beats-1`, go to BURST.
  - State BURST: each accepted beat decrements `beat_cnt`. Reaching 0 returns to IDLE.
  - In BURST, routing ignores the input source bits; the locked port is used.
- `d_last_o` is set on the beat that completes the response, including every 1-beat response.
- Error beats (`dst >= TUL+2` in IDLE, or size > 12): accepted with ready=1, dropped, and `route_err_o` is set.
  - An oversize burst consumes no burst state; each of its beats is dropped individually.
  - `route_err_o` stays set until reset.
- The low source bits are forwarded unchanged as `d_source_o`.
- Per-port FIFO rules:
  - Push on an accepted non-error beat to `dst`.
  - Pop on `d_valid_o[i] & d_ready_i[i]`.
  - Push and pop in the same cycle leave the count unchanged.
  - When full, ready=0 even if a pop occurs in the same cycle.
- Reset mid-burst: the burst state, all FIFO contents and the error flag are discarded.

## Timing
- Reset values:
  - `d_valid_o` = 0 on all ports.
  - `route_err_o` = 0.
  - Burst state = IDLE, `beat_cnt` = 0, all FIFO counts = 0.
  - `l2_d_ready_o` = 1 once reset is released.
  - Data/field outputs are don't-care while valid = 0.
- Latency: a beat accepted at edge N is presented with `d_valid_o` = 1 after edge N.
- Throughput: one beat per cycle per port with `d_ready_i` held high; the 2-entry FIFO hides the ready round trip.
- Handshake: a port holds `d_valid_o` and all its fields stable until accepted.
- Ordering: beats within a port leave in arrival order. Ports are independent, so a stalled port blocks L2 only while the beat at the head of the L2 channel targets that port.

## Structure
- Package `tl_d_pkg` holds:
  - localparams `TL_D_ACCESSACK = 0`, `TL_D_ACCESSACKDATA = 1`, `TL_D_GRANT = 4`, `TL_D_GRANTDATA = 5`, `TL_D_RELEASEACK = 6`.
  - function `tl_d_beats(opcode, size)`.
  - packed struct `tl_d_beat_t {opcode, param, size, source, sink, denied, corrupt, data, last}`.
- Sub-module `tl_d_fifo2`: a 2-entry FIFO of `tl_d_beat_t` with count output, instantiated once per port.

## Test plan
- Single-beat responses: AccessAck with source `{2'd2, 1'b1}` -> port 2 `d_valid_o` one cycle later, `d_source_o` = 1, `d_last_o` = 1.
- Burst: AccessAckData size=6 to port 1 -> 4 beats routed to port 1, `d_last_o` only on beat 4. During beats 2-4, source bits changed to port 3 are ignored.
- Backpressure: hold port 0 `d_ready_i` = 0 and send 3 beats to port 0 -> `l2_d_ready_o` drops after 2 beats. Raising ready drains them in order, then the 3rd is accepted.
- Independence: port 0 stalled and full, beat for port 3 at the head of L2 -> accepted immediately and delivered.
- Errors:
  - TUL=1 (3 ports), source port index 3 -> beat accepted, not delivered, `route_err_o` = 1 and stays set.
  - Size=13 AccessAckData -> dropped, `route_err_o` = 1.
- Reset: assert `l2_cache_rst_ni` mid-burst (beat 2 of 4) -> all `d_valid_o` = 0. After release, a new 1-beat response routes normally from IDLE.
